// File: rtl/lsb.sv
// lsb -- load/store buffer for the out-of-order core.
//
// Holds load/store micro-ops in program order in a circular FIFO. While queued, each entry
// resolves its register operands by snooping the RS result bus (cdb_*) and the ROB commit
// broadcast (upd_*). The head entry is issued, one access at a time, to the memory
// controller. Loads return (tag, data) to the ROB; stores wait for an explicit ROB commit
// notice before they issue. A clear flush drops every uncommitted entry.
//
// Ports:
//   clk_in, rst_in (async, active-low)  clock and reset
//   rdy_in                              global enable; low freezes all state and outputs
//   clear                               ROB flush pulse
//   dec_*                               dispatch of one op (operand ready/tag/value, imm)
//   cdb_*, upd_*                        result broadcasts (cdb wins on a tag tie)
//   commit_valid/commit_tag             marks a queued store as committed
//   mem_req/we/addr/wdata/width         request to memory, held until mem_done
//   mem_done/mem_rdata                  completion pulse and raw right-aligned load data
//   lsb_full                            registered back-pressure (one cycle of slack)
//   rob_valid/rob_tag/rob_data          load-completion pulse to the ROB
module lsb #(
  parameter int unsigned LSB_WIDTH = 3,
  parameter int unsigned LSB_SIZE  = 8,
  parameter int unsigned ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 dec_valid,
  input  logic                 dec_store,
  input  logic [2:0]           dec_funct3,
  input  logic [ROB_WIDTH-1:0] dec_tag,
  input  logic                 dec_qj_rdy,
  input  logic [ROB_WIDTH-1:0] dec_qj_tag,
  input  logic [31:0]          dec_vj,
  input  logic                 dec_qk_rdy,
  input  logic [ROB_WIDTH-1:0] dec_qk_tag,
  input  logic [31:0]          dec_vk,
  input  logic [31:0]          dec_imm,
  input  logic                 cdb_valid,
  input  logic [ROB_WIDTH-1:0] cdb_tag,
  input  logic [31:0]          cdb_data,
  input  logic                 upd_valid,
  input  logic [ROB_WIDTH-1:0] upd_tag,
  input  logic [31:0]          upd_data,
  input  logic                 commit_valid,
  input  logic [ROB_WIDTH-1:0] commit_tag,
  input  logic                 mem_done,
  input  logic [31:0]          mem_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [1:0]           mem_width,
  output logic                 lsb_full,
  output logic                 rob_valid,
  output logic [ROB_WIDTH-1:0] rob_tag,
  output logic [31:0]          rob_data
);

  localparam int unsigned CW = LSB_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

  state_e               r_state;
  logic [LSB_WIDTH-1:0] r_head;
  logic [LSB_WIDTH-1:0] r_tail;
  logic [CW-1:0]        r_count;

  // Per-entry storage
  logic [LSB_SIZE-1:0]  r_valid;
  logic [LSB_SIZE-1:0]  r_store;
  logic [LSB_SIZE-1:0]  r_qj_rdy;
  logic [LSB_SIZE-1:0]  r_qk_rdy;
  logic [LSB_SIZE-1:0]  r_committed;
  logic [2:0]           r_funct3 [LSB_SIZE];
  logic [ROB_WIDTH-1:0] r_tag    [LSB_SIZE];
  logic [ROB_WIDTH-1:0] r_qj_tag [LSB_SIZE];
  logic [ROB_WIDTH-1:0] r_qk_tag [LSB_SIZE];
  logic [31:0]          r_vj     [LSB_SIZE];
  logic [31:0]          r_vk     [LSB_SIZE];
  logic [31:0]          r_imm    [LSB_SIZE];

  // Registered outputs
  logic                 r_mem_req;
  logic                 r_mem_we;
  logic [31:0]          r_mem_addr;
  logic [31:0]          r_mem_wdata;
  logic [1:0]           r_mem_width;
  logic                 r_lsb_full;
  logic                 r_rob_valid;
  logic [ROB_WIDTH-1:0] r_rob_tag;
  logic [31:0]          r_rob_data;

  logic                 w_issuable;
  logic                 w_issue;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_dec_qj_rdy;
  logic [31:0]          w_dec_vj;
  logic                 w_dec_qk_rdy;
  logic [31:0]          w_dec_vk;
  logic [LSB_WIDTH-1:0] w_base;
  logic [CW-1:0]        w_remain;
  logic [CW-1:0]        w_ccnt;
  logic                 w_run;
  logic [LSB_WIDTH-1:0] w_idx;
  logic [LSB_WIDTH-1:0] w_off;
  logic [LSB_SIZE-1:0]  w_keep;
  logic [CW-1:0]        w_count_nxt;

  function automatic logic [31:0] f_ext(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  f_ext = {{24{d[7]}}, d[7:0]};
      3'b001:  f_ext = {{16{d[15]}}, d[15:0]};
      3'b100:  f_ext = {24'h0, d[7:0]};
      3'b101:  f_ext = {16'h0, d[15:0]};
      default: f_ext = d;
    endcase
  endfunction

  always_comb begin
    w_issuable = r_valid[r_head] && r_qj_rdy[r_head] &&
                 (!r_store[r_head] || (r_qk_rdy[r_head] && r_committed[r_head]));
    // A load at the head is being flushed this cycle, so it must not start.
    w_issue    = w_issuable && !(clear && !r_store[r_head]);
    w_pop      = (r_state == StBusy) && mem_done;
    w_push     = dec_valid && !clear;
  end

  // Operands of the op being dispatched, including a same-cycle broadcast.
  always_comb begin
    w_dec_qj_rdy = dec_qj_rdy;
    w_dec_vj     = dec_vj;
    if (!dec_qj_rdy) begin
      if (cdb_valid && cdb_tag == dec_qj_tag) begin
        w_dec_qj_rdy = 1'b1;
        w_dec_vj     = cdb_data;
      end else if (upd_valid && upd_tag == dec_qj_tag) begin
        w_dec_qj_rdy = 1'b1;
        w_dec_vj     = upd_data;
      end
    end
    w_dec_qk_rdy = dec_qk_rdy;
    w_dec_vk     = dec_vk;
    if (!dec_store) begin
      w_dec_qk_rdy = 1'b1;
    end else if (!dec_qk_rdy) begin
      if (cdb_valid && cdb_tag == dec_qk_tag) begin
        w_dec_qk_rdy = 1'b1;
        w_dec_vk     = cdb_data;
      end else if (upd_valid && upd_tag == dec_qk_tag) begin
        w_dec_qk_rdy = 1'b1;
        w_dec_vk     = upd_data;
      end
    end
  end

  // Committed stores form a prefix from the (post-pop) head; count it for clear.
  always_comb begin
    w_base   = r_head + LSB_WIDTH'(w_pop);
    w_remain = r_count - CW'(w_pop);
    w_ccnt   = '0;
    w_run    = 1'b1;
    w_idx    = '0;
    w_off    = '0;
    for (int i = 0; i < LSB_SIZE; i++) begin
      w_idx = w_base + LSB_WIDTH'(i);
      if (w_run && CW'(i) < w_remain && r_valid[w_idx] && r_store[w_idx] &&
          r_committed[w_idx]) begin
        w_ccnt = w_ccnt + CW'(1);
      end else begin
        w_run = 1'b0;
      end
    end
    for (int j = 0; j < LSB_SIZE; j++) begin
      w_off     = LSB_WIDTH'(j) - w_base;
      w_keep[j] = {1'b0, w_off} < w_ccnt;
    end
    if (clear) begin
      w_count_nxt = w_ccnt;
    end else begin
      w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= StIdle;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_valid     <= '0;
      r_store     <= '0;
      r_qj_rdy    <= '0;
      r_qk_rdy    <= '0;
      r_committed <= '0;
      for (int i = 0; i < LSB_SIZE; i++) begin
        r_funct3[i] <= '0;
        r_tag[i]    <= '0;
        r_qj_tag[i] <= '0;
        r_qk_tag[i] <= '0;
        r_vj[i]     <= '0;
        r_vk[i]     <= '0;
        r_imm[i]    <= '0;
      end
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_width <= '0;
      r_lsb_full  <= 1'b0;
      r_rob_valid <= 1'b0;
      r_rob_tag   <= '0;
      r_rob_data  <= '0;
    end else if (rdy_in) begin
      r_rob_valid <= 1'b0;

      // Operand snooping and store commit on queued entries
      for (int i = 0; i < LSB_SIZE; i++) begin
        if (r_valid[i]) begin
          if (!r_qj_rdy[i]) begin
            if (cdb_valid && cdb_tag == r_qj_tag[i]) begin
              r_qj_rdy[i] <= 1'b1;
              r_vj[i]     <= cdb_data;
            end else if (upd_valid && upd_tag == r_qj_tag[i]) begin
              r_qj_rdy[i] <= 1'b1;
              r_vj[i]     <= upd_data;
            end
          end
          if (!r_qk_rdy[i]) begin
            if (cdb_valid && cdb_tag == r_qk_tag[i]) begin
              r_qk_rdy[i] <= 1'b1;
              r_vk[i]     <= cdb_data;
            end else if (upd_valid && upd_tag == r_qk_tag[i]) begin
              r_qk_rdy[i] <= 1'b1;
              r_vk[i]     <= upd_data;
            end
          end
          if (commit_valid && r_store[i] && r_tag[i] == commit_tag) begin
            r_committed[i] <= 1'b1;
          end
        end
      end

      case (r_state)
        StIdle: begin
          if (w_issue) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= r_store[r_head];
            r_mem_addr  <= r_vj[r_head] + r_imm[r_head];
            r_mem_wdata <= r_vk[r_head];
            r_mem_width <= r_funct3[r_head][1:0];
            r_state     <= StBusy;
          end
        end
        StBusy: begin
          if (mem_done) begin
            r_mem_req <= 1'b0;
            r_state   <= StIdle;
            if (!r_store[r_head] && !clear) begin
              r_rob_valid <= 1'b1;
              r_rob_tag   <= r_tag[r_head];
              r_rob_data  <= f_ext(r_funct3[r_head], mem_rdata);
            end
          end else if (clear && !r_store[r_head]) begin
            // The load's entry goes away now; its response is still owed.
            r_state <= StDrain;
          end
        end
        StDrain: begin
          if (mem_done) begin
            r_mem_req <= 1'b0;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase

      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
      end

      if (w_push) begin
        r_valid[r_tail]     <= 1'b1;
        r_store[r_tail]     <= dec_store;
        r_funct3[r_tail]    <= dec_funct3;
        r_tag[r_tail]       <= dec_tag;
        r_qj_rdy[r_tail]    <= w_dec_qj_rdy;
        r_qj_tag[r_tail]    <= dec_qj_tag;
        r_vj[r_tail]        <= w_dec_vj;
        r_qk_rdy[r_tail]    <= w_dec_qk_rdy;
        r_qk_tag[r_tail]    <= dec_qk_tag;
        r_vk[r_tail]        <= w_dec_vk;
        r_imm[r_tail]       <= dec_imm;
        r_committed[r_tail] <= 1'b0;
      end

      r_head <= w_base;
      if (clear) begin
        r_valid <= r_valid & w_keep;
        r_tail  <= w_base + LSB_WIDTH'(w_ccnt);
      end else begin
        r_tail  <= r_tail + LSB_WIDTH'(w_push);
      end
      r_count    <= w_count_nxt;
      r_lsb_full <= (32'(w_count_nxt) + 32'd2) >= LSB_SIZE;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_width = r_mem_width;
  assign lsb_full  = r_lsb_full;
  assign rob_valid = r_rob_valid;
  assign rob_tag   = r_rob_tag;
  assign rob_data  = r_rob_data;

endmodule

// File: tb/tb_lsb.sv
module tb_lsb;
  localparam int SZ = 8;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        clear = 1'b0;
  logic        dec_valid = 1'b0;
  logic        dec_store = 1'b0;
  logic [2:0]  dec_funct3 = '0;
  logic [3:0]  dec_tag = '0;
  logic        dec_qj_rdy = 1'b0;
  logic [3:0]  dec_qj_tag = '0;
  logic [31:0] dec_vj = '0;
  logic        dec_qk_rdy = 1'b0;
  logic [3:0]  dec_qk_tag = '0;
  logic [31:0] dec_vk = '0;
  logic [31:0] dec_imm = '0;
  logic        cdb_valid = 1'b0;
  logic [3:0]  cdb_tag = '0;
  logic [31:0] cdb_data = '0;
  logic        upd_valid = 1'b0;
  logic [3:0]  upd_tag = '0;
  logic [31:0] upd_data = '0;
  logic        commit_valid = 1'b0;
  logic [3:0]  commit_tag = '0;
  logic        mem_done = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_req, mem_we, lsb_full, rob_valid;
  logic [31:0] mem_addr, mem_wdata, rob_data;
  logic [1:0]  mem_width;
  logic [3:0]  rob_tag;

  lsb #(.LSB_WIDTH(3), .LSB_SIZE(8), .ROB_WIDTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .dec_valid(dec_valid), .dec_store(dec_store), .dec_funct3(dec_funct3), .dec_tag(dec_tag),
    .dec_qj_rdy(dec_qj_rdy), .dec_qj_tag(dec_qj_tag), .dec_vj(dec_vj),
    .dec_qk_rdy(dec_qk_rdy), .dec_qk_tag(dec_qk_tag), .dec_vk(dec_vk), .dec_imm(dec_imm),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .upd_valid(upd_valid), .upd_tag(upd_tag), .upd_data(upd_data),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_width(mem_width), .lsb_full(lsb_full),
    .rob_valid(rob_valid), .rob_tag(rob_tag), .rob_data(rob_data)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
  } req_t;
  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] data;
  } rob_t;

  req_t req_q[$];
  rob_t rob_q[$];
  req_t er;
  rob_t eb;

  // Dispatch into a full buffer is a protocol violation.
  always @(posedge clk_in) begin
    if (rst_in && dec_valid && dut.r_count == 4'(SZ)) begin
      n_fail++;
      $display("FAIL protocol: dec_valid with count=%0d, required count<%0d", dut.r_count, SZ);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_op(input logic st, input logic [2:0] f3, input logic [3:0] tag,
                          input logic jr, input logic [3:0] jt, input logic [31:0] vj,
                          input logic kr, input logic [3:0] kt, input logic [31:0] vk,
                          input logic [31:0] imm);
    dec_valid = 1'b1; dec_store = st; dec_funct3 = f3; dec_tag = tag;
    dec_qj_rdy = jr; dec_qj_tag = jt; dec_vj = vj;
    dec_qk_rdy = kr; dec_qk_tag = kt; dec_vk = vk; dec_imm = imm;
  endtask

  task automatic dispatch(input logic st, input logic [2:0] f3, input logic [3:0] tag,
                          input logic jr, input logic [3:0] jt, input logic [31:0] vj,
                          input logic kr, input logic [3:0] kt, input logic [31:0] vk,
                          input logic [31:0] imm);
    drive_op(st, f3, tag, jr, jt, vj, kr, kt, vk, imm);
    tick();
    dec_valid = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!mem_req && n < 50) begin
      tick();
      n++;
    end
    n_tests++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL %s wait_req: mem_req=%b after %0d cycles, required 1", name, mem_req, n);
    end
  endtask

  task automatic finish_mem(input logic [31:0] rdata);
    mem_rdata = rdata;
    mem_done  = 1'b1;
    tick();
    mem_done  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_tests++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_width, lsb_full, rob_valid, rob_tag,
         rob_data} !== '0 || dut.r_count !== 4'd0 || dut.r_head !== 3'd0 ||
        dut.r_tail !== 3'd0) begin
      n_fail++;
      $display("FAIL reset: req=%b we=%b addr=%h full=%b rob_v=%b count=%0d, required all 0",
               mem_req, mem_we, mem_addr, lsb_full, rob_valid, dut.r_count);
    end
    #2 rst_in = 1'b1;
    tick();
  endtask

  task automatic test_load_word();
    req_q.push_back('{we: 1'b0, addr: 32'h104, wdata: 32'h0, width: 2'd2});
    rob_q.push_back('{tag: 4'd1, data: 32'hDEADBEEF});
    dispatch(1'b0, 3'b010, 4'd1, 1'b1, 4'd0, 32'h100, 1'b0, 4'd0, 32'h0, 32'd4);
    n_tests++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL lw_latency: mem_req=%b, required 0", mem_req);
    end
    tick();
    er = req_q.pop_front();
    n_tests++;
    if (mem_req !== 1'b1 || mem_we !== er.we || mem_addr !== er.addr || mem_width !== er.width)
    begin
      n_fail++;
      $display("FAIL lw_req: req=%b we=%b addr=%h width=%0d, required 1 %b %h %0d",
               mem_req, mem_we, mem_addr, mem_width, er.we, er.addr, er.width);
    end
    // mem_done while paused must be ignored.
    rdy_in = 1'b0; mem_done = 1'b1; mem_rdata = 32'h0BADF00D;
    tick();
    rdy_in = 1'b1; mem_done = 1'b0;
    n_tests++;
    if (mem_req !== 1'b1 || rob_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rdy_pause: req=%b rob_v=%b, required 1 0", mem_req, rob_valid);
    end
    finish_mem(32'hDEADBEEF);
    eb = rob_q.pop_front();
    n_tests++;
    if (mem_req !== 1'b0 || rob_valid !== 1'b1 || rob_tag !== eb.tag || rob_data !== eb.data ||
        dut.r_count !== 4'd0) begin
      n_fail++;
      $display("FAIL lw_done: req=%b rob_v=%b tag=%0d data=%h count=%0d, required 0 1 %0d %h 0",
               mem_req, rob_valid, rob_tag, rob_data, dut.r_count, eb.tag, eb.data);
    end
    tick();
    n_tests++;
    if (rob_valid !== 1'b0) begin
      n_fail++; $display("FAIL rob_pulse: rob_valid=%b, required 0", rob_valid);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] raw [4] = '{32'h00000080, 32'h12345680, 32'h00008001, 32'hFFFF8001};
    logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
    for (int i = 0; i < 4; i++) begin
      req_q.push_back('{we: 1'b0, addr: 32'h200 + 32'(i), wdata: 32'h0,
                        width: (f3s[i][0] ? 2'd1 : 2'd0)});
      rob_q.push_back('{tag: 4'(2 + i), data: exp[i]});
      dispatch(1'b0, f3s[i], 4'(2 + i), 1'b1, 4'd0, 32'h200, 1'b0, 4'd0, 32'h0, 32'(i));
    end
    for (int i = 0; i < 4; i++) begin
      wait_req("ext");
      er = req_q.pop_front();
      n_tests++;
      if (mem_we !== er.we || mem_addr !== er.addr || mem_width !== er.width) begin
        n_fail++;
        $display("FAIL ext_req%0d: we=%b addr=%h width=%0d, required %b %h %0d",
                 i, mem_we, mem_addr, mem_width, er.we, er.addr, er.width);
      end
      finish_mem(raw[i]);
      eb = rob_q.pop_front();
      n_tests++;
      if (rob_valid !== 1'b1 || rob_tag !== eb.tag || rob_data !== eb.data) begin
        n_fail++;
        $display("FAIL ext_data%0d: rob_v=%b tag=%0d data=%h, required 1 %0d %h",
                 i, rob_valid, rob_tag, rob_data, eb.tag, eb.data);
      end
    end
  endtask

  task automatic test_store_gating();
    bit early = 1'b0;
    req_q.push_back('{we: 1'b1, addr: 32'h308, wdata: 32'hCAFEF00D, width: 2'd2});
    dispatch(1'b1, 3'b010, 4'd3, 1'b1, 4'd0, 32'h300, 1'b1, 4'd0, 32'hCAFEF00D, 32'd8);
    for (int i = 0; i < 5; i++) begin
      if (mem_req) early = 1'b1;
      tick();
    end
    n_tests++;
    if (early) begin
      n_fail++; $display("FAIL st_gate: mem_req=1 before commit, required 0");
    end
    commit_valid = 1'b1; commit_tag = 4'd3;
    tick();
    commit_valid = 1'b0;
    n_tests++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL st_commit_latency: mem_req=%b, required 0", mem_req);
    end
    tick();
    er = req_q.pop_front();
    n_tests++;
    if (mem_req !== 1'b1 || mem_we !== er.we || mem_addr !== er.addr ||
        mem_wdata !== er.wdata || mem_width !== er.width) begin
      n_fail++;
      $display("FAIL st_req: req=%b we=%b addr=%h wdata=%h width=%0d, required 1 %b %h %h %0d",
               mem_req, mem_we, mem_addr, mem_wdata, mem_width, er.we, er.addr, er.wdata,
               er.width);
    end
    finish_mem(32'h0);
    n_tests++;
    if (mem_req !== 1'b0 || rob_valid !== 1'b0 || dut.r_count !== 4'd0) begin
      n_fail++;
      $display("FAIL st_done: req=%b rob_v=%b count=%0d, required 0 0 0",
               mem_req, rob_valid, dut.r_count);
    end
  endtask

  task automatic test_snoop();
    dispatch(1'b0, 3'b010, 4'd6, 1'b0, 4'd5, 32'h0, 1'b0, 4'd0, 32'h0, 32'h10);
    tick(); tick();
    n_tests++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL snoop_wait: mem_req=%b, required 0", mem_req);
    end
    // Same tag on both buses: cdb has priority.
    cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_data = 32'h2000;
    upd_valid = 1'b1; upd_tag = 4'd5; upd_data = 32'h9000;
    tick();
    cdb_valid = 1'b0; upd_valid = 1'b0;
    n_tests++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL snoop_latency: mem_req=%b, required 0", mem_req);
    end
    tick();
    n_tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h2010) begin
      n_fail++; $display("FAIL snoop_addr: req=%b addr=%h, required 1 00002010", mem_req, mem_addr);
    end
    rob_q.push_back('{tag: 4'd6, data: 32'h55});
    finish_mem(32'h55);
    eb = rob_q.pop_front();
    n_tests++;
    if (rob_valid !== 1'b1 || rob_tag !== eb.tag || rob_data !== eb.data) begin
      n_fail++;
      $display("FAIL snoop_rob: rob_v=%b tag=%0d data=%h, required 1 %0d %h",
               rob_valid, rob_tag, rob_data, eb.tag, eb.data);
    end
    // Broadcast during the dispatch cycle itself.
    drive_op(1'b0, 3'b010, 4'd7, 1'b0, 4'd9, 32'h0, 1'b0, 4'd0, 32'h0, 32'h20);
    upd_valid = 1'b1; upd_tag = 4'd9; upd_data = 32'h3000;
    tick();
    dec_valid = 1'b0; upd_valid = 1'b0;
    tick();
    n_tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h3020) begin
      n_fail++; $display("FAIL snoop_disp: req=%b addr=%h, required 1 00003020", mem_req, mem_addr);
    end
    finish_mem(32'h77);
    n_tests++;
    if (rob_valid !== 1'b1 || rob_tag !== 4'd7 || rob_data !== 32'h77) begin
      n_fail++;
      $display("FAIL snoop_disp_rob: rob_v=%b tag=%0d data=%h, required 1 7 00000077",
               rob_valid, rob_tag, rob_data);
    end
  endtask

  task automatic test_clear();
    bit stray = 1'b0;
    dispatch(1'b1, 3'b010, 4'd1, 1'b1, 4'd0, 32'h400, 1'b1, 4'd0, 32'h11, 32'h0);
    dispatch(1'b0, 3'b010, 4'd2, 1'b1, 4'd0, 32'h500, 1'b0, 4'd0, 32'h0, 32'h0);
    dispatch(1'b1, 3'b000, 4'd3, 1'b1, 4'd0, 32'h600, 1'b1, 4'd0, 32'h22, 32'h0);
    commit_valid = 1'b1; commit_tag = 4'd1;
    tick();
    commit_valid = 1'b0;
    wait_req("clr_st");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_tests++;
    if (dut.r_count !== 4'd1 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h400) begin
      n_fail++;
      $display("FAIL clr_keep: count=%0d req=%b we=%b addr=%h, required 1 1 1 00000400",
               dut.r_count, mem_req, mem_we, mem_addr);
    end
    finish_mem(32'h0);
    n_tests++;
    if (mem_req !== 1'b0 || rob_valid !== 1'b0 || dut.r_count !== 4'd0) begin
      n_fail++;
      $display("FAIL clr_st_done: req=%b rob_v=%b count=%0d, required 0 0 0",
               mem_req, rob_valid, dut.r_count);
    end
    commit_valid = 1'b1; commit_tag = 4'd3;
    tick();
    commit_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (mem_req) stray = 1'b1;
      tick();
    end
    n_tests++;
    if (stray) begin
      n_fail++; $display("FAIL clr_flushed: mem_req=1 for a flushed entry, required 0");
    end
    // Clear with a load in flight: drain, no completion.
    dispatch(1'b0, 3'b010, 4'd4, 1'b1, 4'd0, 32'h700, 1'b0, 4'd0, 32'h0, 32'h0);
    wait_req("drain");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    n_tests++;
    if (mem_req !== 1'b1 || dut.r_count !== 4'd0) begin
      n_fail++;
      $display("FAIL drain_hold: req=%b count=%0d, required 1 0", mem_req, dut.r_count);
    end
    finish_mem(32'h1234);
    n_tests++;
    if (mem_req !== 1'b0 || rob_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_done: req=%b rob_v=%b, required 0 0", mem_req, rob_valid);
    end
    // Clear coinciding with a load's mem_done.
    dispatch(1'b0, 3'b010, 4'd5, 1'b1, 4'd0, 32'h800, 1'b0, 4'd0, 32'h0, 32'h0);
    wait_req("clr_done");
    clear = 1'b1; mem_done = 1'b1; mem_rdata = 32'hBBBB;
    tick();
    clear = 1'b0; mem_done = 1'b0;
    n_tests++;
    if (mem_req !== 1'b0 || rob_valid !== 1'b0 || dut.r_count !== 4'd0) begin
      n_fail++;
      $display("FAIL clr_done: req=%b rob_v=%b count=%0d, required 0 0 0",
               mem_req, rob_valid, dut.r_count);
    end
    dispatch(1'b0, 3'b010, 4'd6, 1'b1, 4'd0, 32'h900, 1'b0, 4'd0, 32'h0, 32'h0);
    wait_req("after_clr");
    finish_mem(32'hA5A5);
    n_tests++;
    if (rob_valid !== 1'b1 || rob_tag !== 4'd6 || rob_data !== 32'hA5A5) begin
      n_fail++;
      $display("FAIL after_clr: rob_v=%b tag=%0d data=%h, required 1 6 0000a5a5",
               rob_valid, rob_tag, rob_data);
    end
  endtask

  task automatic serve_check(input string name);
    er = req_q.pop_front();
    n_tests++;
    if (mem_addr !== er.addr || mem_we !== er.we) begin
      n_fail++;
      $display("FAIL %s req: addr=%h we=%b, required %h %b", name, mem_addr, mem_we, er.addr, er.we);
    end
  endtask

  task automatic test_full_wrap();
    logic [31:0] a;
    for (int k = 0; k < 10; k++) begin
      a = 32'h1000 + 32'(k * 4);
      req_q.push_back('{we: 1'b0, addr: a, wdata: 32'h0, width: 2'd2});
      rob_q.push_back('{tag: 4'(k), data: a ^ 32'h5A5A0000});
    end
    for (int k = 0; k < 6; k++) begin
      dispatch(1'b0, 3'b010, 4'(k), 1'b1, 4'd0, 32'h1000 + 32'(k * 4), 1'b0, 4'd0, 32'h0, 32'h0);
      n_tests++;
      if (lsb_full !== (k >= 5)) begin
        n_fail++;
        $display("FAIL full_at%0d: lsb_full=%b, required %b", k + 1, lsb_full, (k >= 5));
      end
    end
    // Each remaining dispatch lands on the same edge as a pop.
    for (int k = 6; k < 10; k++) begin
      wait_req("wrap");
      serve_check("wrap");
      drive_op(1'b0, 3'b010, 4'(k), 1'b1, 4'd0, 32'h1000 + 32'(k * 4), 1'b0, 4'd0, 32'h0, 32'h0);
      mem_rdata = mem_addr ^ 32'h5A5A0000;
      mem_done = 1'b1;
      tick();
      dec_valid = 1'b0; mem_done = 1'b0;
      eb = rob_q.pop_front();
      n_tests++;
      if (rob_valid !== 1'b1 || rob_tag !== eb.tag || rob_data !== eb.data ||
          dut.r_count !== 4'd6 || lsb_full !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_pop%0d: rob_v=%b tag=%0d data=%h count=%0d full=%b, required 1 %0d %h 6 1",
                 k, rob_valid, rob_tag, rob_data, dut.r_count, lsb_full, eb.tag, eb.data);
      end
    end
    while (rob_q.size() > 0) begin
      wait_req("drain_q");
      serve_check("drain_q");
      finish_mem(mem_addr ^ 32'h5A5A0000);
      eb = rob_q.pop_front();
      n_tests++;
      if (rob_valid !== 1'b1 || rob_tag !== eb.tag || rob_data !== eb.data) begin
        n_fail++;
        $display("FAIL fifo_order: rob_v=%b tag=%0d data=%h, required 1 %0d %h",
                 rob_valid, rob_tag, rob_data, eb.tag, eb.data);
      end
    end
    n_tests++;
    if (lsb_full !== 1'b0 || dut.r_count !== 4'd0) begin
      n_fail++;
      $display("FAIL wrap_end: full=%b count=%0d, required 0 0", lsb_full, dut.r_count);
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_ext();
    test_store_gating();
    test_snoop();
    test_clear();
    test_full_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsb.md
# lsb

Load/store buffer for the out-of-order core: the memory-side counterpart of the reorder buffer's store-commit and load-completion interface. It accepts load/store micro-ops from the decoder in program order and resolves their register operands by snooping the RS result bus and ROB commit broadcasts. It issues one access at a time from its head to the memory controller and returns load results to the ROB as `(tag, data)`. Stores are performed only after the ROB commits them; on `clear`, all speculative entries are discarded.

## Interface
- `LSB_WIDTH`, 3, log2 of entry count
- `LSB_SIZE`, 8, entry count
- `ROB_WIDTH`, 4, ROB tag width

- `clk_in`  in  1  clock
- `rst_in`  in  1  asynchronous, active-low reset
- `rdy_in`  in  1  global enable; low freezes all state, and outputs hold
- `clear`  in  1  ROB flush pulse
- `dec_valid`  in  1  dispatch strobe
- `dec_store`  in  1  1 = store, 0 = load
- `dec_funct3`  in  3  RISC-V funct3
- `dec_tag`  in  ROB_WIDTH  ROB entry of the op
- `dec_qj_rdy` / `dec_qj_tag` / `dec_vj`  in  1/ROB_WIDTH/32  base operand: ready flag, producer tag, value
- `dec_qk_rdy` / `dec_qk_tag` / `dec_vk`  in  1/ROB_WIDTH/32  store-data operand
- `dec_imm`  in  32  sign-extended offset
- `cdb_valid` / `cdb_tag` / `cdb_data`  in  1/ROB_WIDTH/32  RS result broadcast
- `upd_valid` / `upd_tag` / `upd_data`  in  1/ROB_WIDTH/32  ROB commit broadcast
- `commit_valid` / `commit_tag`  in  1/ROB_WIDTH  ROB store-commit notice
- `mem_done`  in  1  one-cycle completion pulse from the memory controller
- `mem_rdata`  in  32  load data, raw and right-aligned; valid with `mem_done`
- `mem_req`  out  1  request; held until `mem_done`
- `mem_we` / `mem_addr` / `mem_wdata` / `mem_width`  out  1/32/32/2  request fields; `mem_width` 0 = byte, 1 = half, 2 = word
- `lsb_full`  out  1  dispatch back-pressure
- `rob_valid` / `rob_tag` / `rob_data`  out  1/ROB_WIDTH/32  load-completion pulse to the ROB

## Operation
- **Queue structure**
  - Circular FIFO: `head`, `tail` (`LSB_WIDTH` bits, natural wrap) and `count` (`LSB_WIDTH+1` bits).
  - Per-entry fields: valid, store, funct3, tag, qj/qk ready flag + tag + value, imm, committed.
- **Dispatch**
  - On `dec_valid`, write the entry at `tail`, then increment `tail`.
  - If `cdb` or `upd` broadcasts a tag the dispatched op is waiting on in the same cycle, capture the value and mark the operand ready.
  - Loads ignore qk: it is forced ready.
- **Operand snooping** (every cycle, all valid entries)
  - A not-ready operand whose tag matches a valid broadcast takes that data.
  - If `cdb` and `upd` match the same tag in one cycle, `cdb` wins.
- **Store commit**: `commit_valid` sets `committed` on the valid store entry whose tag equals `commit_tag`.
- **FSM states**
  - IDLE:
    - The head entry is issuable when it is valid, qj is ready, and it is either a load, or a store with qk ready and `committed` set.
    - When issuable: register `mem_req=1`, `mem_addr = vj + imm` (mod 2^32), `mem_we = store`, `mem_width = funct3[1:0]`, `mem_wdata = vk`. Go to BUSY.
  - BUSY:
    - Hold all request fields until `mem_done`.
    - On `mem_done`: drop `mem_req` and pop the head.
    - For a load: pulse `rob_valid` with `rob_tag` = entry tag and `rob_data` = `mem_rdata` extended per funct3 (000 LB sign-8, 001 LH sign-16, 010 LW, 100 LBU zero-8, 101 LHU zero-16).
    - Go to IDLE.
  - DRAIN:
    - A load that was in flight at `clear`. Keep `mem_req` until `mem_done`, discard the data, send no `rob_valid`, then go to IDLE.
    - The load entry itself was already removed at `clear`.
- **Clear**
  - Remove all uncommitted entries. Committed stores always form a prefix from `head`, so set `tail = head + committed_store_count` and `count = committed_store_count`.
  - An in-flight committed store continues in BUSY.
  - An in-flight load moves to DRAIN.
  - `clear` overrides `dec_valid` in the same cycle.
- **lsb_full**
  - Registered; asserted when the post-update `count + 2 >= LSB_SIZE`.
  - This gives one cycle of dispatch slack.
  - `dec_valid` while `count == LSB_SIZE` is a protocol violation; the bench asserts on it.

## Timing
- Reset values: `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `mem_width=0`, `lsb_full=0`, `rob_valid=0`, `rob_tag=0`, `rob_data=0`; `head=tail=count=0`; all valid and committed flags 0; FSM in IDLE.
- Issue:
  - Head becomes issuable at edge N → `mem_req` high after edge N.
  - `mem_done` sampled at edge M → `mem_req` low and `rob_valid` high for one cycle after edge M.
  - Earliest next `mem_req` is after edge M+1.
- An operand broadcast at edge N makes the head issuable at edge N+1.
- `commit_valid` at edge N allows the store to issue at edge N+1.
- Dispatch and pop in the same cycle: `count` is unchanged; `lsb_full` is recomputed.
- `clear` and `mem_done` at the same edge:
  - The completing entry is popped first.
  - A load's `rob_valid` is suppressed; a store completes normally.
  - The FSM goes to IDLE.
- While `rdy_in` is low, `mem_done` is ignored; the controller is paused under the same `rdy_in`.

## Test plan
- **Load word**: LW base ready, `vj=0x100`, `imm=4` → `mem_req`, `mem_addr=0x104`, `mem_width=2`. `mem_done` with `0xDEADBEEF` → `rob_valid`, `rob_data=0xDEADBEEF`, `count` back to 0.
- **Load extension**: LB with `mem_rdata=0x80` → `rob_data=0xFFFFFF80`. LBU with `0x80` → `0x00000080`. LH with `0x8001` → `0xFFFF8001`.
- **Store gating**: SW (tag 3) with both operands ready → no `mem_req` until `commit_valid`, `commit_tag=3`. One cycle later, `mem_req=1`, `mem_we=1`, `mem_wdata=vk`; no `rob_valid` after `mem_done`.
- **Snoop**: load waiting on tag 5 → `cdb` tag 5 data `0x2000` at edge N → `mem_addr=0x2000+imm` after edge N+1. Repeat with the broadcast in the dispatch cycle itself.
- **Clear**: queue holds committed SW, uncommitted LW (in flight is the SW), and SB → `clear` leaves `count=1`. SW completes; the other entries never issue. In a separate case, clear during an in-flight load → DRAIN, no `rob_valid`.
- **Full/wrap**: dispatch 10 ops with pops interleaved → `lsb_full` asserts at `count=6`. Pointers wrap 7→0; results come out in FIFO order.
